// File: rtl/serial_paralelo.sv
// Receive-side deserializer: hunts for the COM symbol in a 1-bit MSB-first stream,
// locks after LOCK_COUNT consecutive aligned COMs, then emits each non-COM byte.
// Optional macro SP_STATUS_EN adds the com_count[7:0] status output.
module serial_paralelo #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
`ifdef SP_STATUS_EN
  ,
  output logic [7:0] com_count
`endif
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    COUNT   = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t      state_q;
  logic [6:0]  sr_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  com_run_q;
  logic [7:0]  data_out_q;
  logic        valid_out_q;
  logic        active_q;
  logic [7:0]  cand_d;
  logic        is_com_d;
  logic        sym_edge_d;
  logic        lock_hit_d;
`ifdef SP_STATUS_EN
  logic [7:0]  com_count_q;
`endif

  // Only the last seven bits need storing; the eighth is the bit sampled now.
  assign cand_d     = {sr_q, data_in};
  assign is_com_d   = (cand_d == COM);
  assign sym_edge_d = (bit_cnt_q == 3'd7);
  assign lock_hit_d = (({1'b0, com_run_q} + 4'd1) == LOCK_N);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      com_run_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
`ifdef SP_STATUS_EN
      com_count_q <= '0;
`endif
    end else begin
      sr_q <= cand_d[6:0];
      case (state_q)
        SEARCH: begin
          if (is_com_d) begin
            bit_cnt_q <= '0;
            if (LOCK_N == 4'd1) begin
              state_q  <= ALIGNED;
              active_q <= 1'b1;
            end else begin
              state_q   <= COUNT;
              com_run_q <= 3'd1;
            end
          end
        end

        COUNT: begin
          bit_cnt_q <= 3'(bit_cnt_q + 3'd1);
          if (sym_edge_d) begin
            if (is_com_d && lock_hit_d) begin
              state_q  <= ALIGNED;
              active_q <= 1'b1;
            end else if (is_com_d) begin
              com_run_q <= 3'(com_run_q + 3'd1);
            end else begin
              state_q   <= SEARCH;
              com_run_q <= '0;
            end
          end
        end

        ALIGNED: begin
          // No exit from lock: a misaligned COM pattern here is just data.
          bit_cnt_q <= 3'(bit_cnt_q + 3'd1);
          if (sym_edge_d) begin
            if (is_com_d) begin
              valid_out_q <= 1'b0;
`ifdef SP_STATUS_EN
              if (com_count_q != 8'hFF) com_count_q <= 8'(com_count_q + 8'd1);
`endif
            end else begin
              valid_out_q <= 1'b1;
              data_out_q  <= cand_d;
            end
          end
        end

        default: begin
          state_q   <= SEARCH;
          bit_cnt_q <= '0;
          com_run_q <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active    = active_q;
`ifdef SP_STATUS_EN
  assign com_count = com_count_q;
`endif

endmodule
